// File: rtl/cbu_pkg.sv
// cbu_pkg: shared types and constants for the conditional branch unit.
//   br_type_t  - branch kind carried on br_type
//   COND_*     - A64 condition-code encodings
//   NZCV_*     - bit positions of the flags within the 4-bit {N,Z,C,V} vector
package cbu_pkg;

    typedef enum logic [1:0] {
        BR_B    = 2'd0,
        BR_COND = 2'd1,
        BR_CBZ  = 2'd2,
        BR_CBNZ = 2'd3
    } br_type_t;

    typedef logic [3:0] cond_t;

    localparam cond_t COND_EQ = 4'b0000;
    localparam cond_t COND_NE = 4'b0001;
    localparam cond_t COND_HS = 4'b0010;
    localparam cond_t COND_LO = 4'b0011;
    localparam cond_t COND_MI = 4'b0100;
    localparam cond_t COND_PL = 4'b0101;
    localparam cond_t COND_VS = 4'b0110;
    localparam cond_t COND_VC = 4'b0111;
    localparam cond_t COND_HI = 4'b1000;
    localparam cond_t COND_LS = 4'b1001;
    localparam cond_t COND_GE = 4'b1010;
    localparam cond_t COND_LT = 4'b1011;
    localparam cond_t COND_GT = 4'b1100;
    localparam cond_t COND_LE = 4'b1101;
    localparam cond_t COND_AL = 4'b1110;
    localparam cond_t COND_NV = 4'b1111;

    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational A64 condition-code evaluator.
// Ports:
//   cond  - 4-bit A64 condition code
//   flags - {N,Z,C,V}
//   pass  - 1 when the condition holds for the given flags
module cond_eval
    import cbu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n = flags[NZCV_N];
        z = flags[NZCV_Z];
        c = flags[NZCV_C];
        v = flags[NZCV_V];
    end

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_HS: pass = c;
            COND_LO: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !(c & !z);
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = !(!z & (n == v));
            // NV behaves as AL in A64.
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_unit.sv
// cond_branch_unit: NZCV flag register plus branch resolution stage behind the ALU.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   alu_valid, set_flags       - live ALU instruction / it writes NZCV
//   alu_negative/zero/overflow/carry_out - ALU flag outputs
//   br_valid/br_ready          - branch request handshake (br_type, br_cond)
//   res_valid/res_ready        - resolution handshake to fetch (res_taken)
//   nzcv                       - architectural flags {N,Z,C,V}
//   taken_count                - saturating count of accepted taken branches
module cond_branch_unit
    import cbu_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic             set_flags,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_type,
    input  logic [3:0]       br_cond,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic [3:0]       nzcv,
    output logic [CNT_W-1:0] taken_count
);

    logic [3:0]       nzcv_q, nzcv_d;
    logic             res_valid_q, res_valid_d;
    logic             res_taken_q, res_taken_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic       flag_wr;
    logic [3:0] live_flags;
    logic [3:0] eff_flags;
    logic       cond_pass;
    logic       taken;
    logic       accept;

    always_comb begin
        flag_wr    = alu_valid & set_flags;
        live_flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
        // Same-cycle flag setter is bypassed so B.cond needs no bubble.
        eff_flags  = flag_wr ? live_flags : nzcv_q;
    end

    cond_eval u_cond_eval (
        .cond  (br_cond),
        .flags (eff_flags),
        .pass  (cond_pass)
    );

    always_comb begin
        taken = 1'b0;
        unique case (br_type_t'(br_type))
            BR_B:    taken = 1'b1;
            BR_COND: taken = cond_pass;
            // CB(N)Z look at the live ALU zero, only meaningful with alu_valid.
            BR_CBZ:  taken = alu_valid & alu_zero;
            BR_CBNZ: taken = alu_valid & !alu_zero;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        br_ready = !res_valid_q | res_ready;
        accept   = br_valid & br_ready;
    end

    always_comb begin
        nzcv_d        = flag_wr ? live_flags : nzcv_q;
        res_valid_d   = res_valid_q;
        res_taken_d   = res_taken_q;
        taken_count_d = taken_count_q;
        if (accept) begin
            res_valid_d = 1'b1;
            res_taken_d = taken;
            if (taken && (taken_count_q != {CNT_W{1'b1}})) begin
                taken_count_d = taken_count_q + CNT_W'(1);
            end
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nzcv_q        <= 4'b0000;
            res_valid_q   <= 1'b0;
            res_taken_q   <= 1'b0;
            taken_count_q <= '0;
        end else begin
            nzcv_q        <= nzcv_d;
            res_valid_q   <= res_valid_d;
            res_taken_q   <= res_taken_d;
            taken_count_q <= taken_count_d;
        end
    end

    always_comb begin
        nzcv        = nzcv_q;
        res_valid   = res_valid_q;
        res_taken   = res_taken_q;
        taken_count = taken_count_q;
    end

endmodule

// File: tb/tb_cond_branch_unit.sv
// tb_cond_branch_unit: directed self-checking bench for cond_branch_unit.
// A second instance with a 3-bit counter shares all inputs to observe saturation.
module tb_cond_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, set_flags;
    logic        alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic        br_valid, br_ready;
    logic [1:0]  br_type;
    logic [3:0]  br_cond;
    logic        res_valid, res_ready, res_taken;
    logic [3:0]  nzcv;
    logic [31:0] taken_count;

    logic        s_br_ready, s_res_valid, s_res_taken;
    logic [3:0]  s_nzcv;
    logic [2:0]  s_taken_count;

    int passed = 0;
    int total  = 0;
    int cnt    = 0;
    logic exp_t;

    always #5 clk = ~clk;

    cond_branch_unit #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .alu_valid(alu_valid), .set_flags(set_flags),
        .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry_out(alu_carry_out), .br_valid(br_valid), .br_ready(br_ready),
        .br_type(br_type), .br_cond(br_cond), .res_valid(res_valid),
        .res_ready(res_ready), .res_taken(res_taken), .nzcv(nzcv),
        .taken_count(taken_count)
    );

    cond_branch_unit #(.CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .alu_valid(alu_valid), .set_flags(set_flags),
        .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry_out(alu_carry_out), .br_valid(br_valid), .br_ready(s_br_ready),
        .br_type(br_type), .br_cond(br_cond), .res_valid(s_res_valid),
        .res_ready(res_ready), .res_taken(s_res_taken), .nzcv(s_nzcv),
        .taken_count(s_taken_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; set_flags = 0;
        alu_negative = 0; alu_zero = 0; alu_overflow = 0; alu_carry_out = 0;
        br_valid = 0; br_type = 2'd0; br_cond = 4'd0; res_ready = 1;
    endtask

    // Flags given as {N,Z,C,V}.
    task automatic set_alu(input logic [3:0] f);
        alu_negative = f[3]; alu_zero = f[2]; alu_carry_out = f[1]; alu_overflow = f[0];
    endtask

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] sat3(input int c);
        return (c > 7) ? 32'd7 : 32'(c);
    endfunction

    initial begin
        // Reset held with random inputs.
        reset = 0;
        idle();
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'($urandom); set_flags = 1'($urandom);
            set_alu(4'($urandom)); br_valid = 1'($urandom);
            br_type = 2'($urandom); br_cond = 4'($urandom); res_ready = 1'($urandom);
            step();
            chk("rst_nzcv", 32'(nzcv), 32'h0);
            chk("rst_res_valid", 32'(res_valid), 32'h0);
        end
        chk("rst_res_taken", 32'(res_taken), 32'h0);
        chk("rst_count", taken_count, 32'h0);
        idle();
        reset = 1;
        #1;
        chk("rst_br_ready", 32'(br_ready), 32'h1);

        // SUBS N0 Z1 C1 V0 then B.EQ / B.NE from the register.
        alu_valid = 1; set_flags = 1; set_alu(4'b0110);
        step();
        chk("subs_nzcv", 32'(nzcv), 32'h6);
        idle();
        br_valid = 1; br_type = 2'd1; br_cond = 4'b0000;
        step();
        cnt++;
        chk("eq_valid", 32'(res_valid), 32'h1);
        chk("eq_taken", 32'(res_taken), 32'h1);
        br_cond = 4'b0001;
        step();
        chk("ne_valid", 32'(res_valid), 32'h1);
        chk("ne_taken", 32'(res_taken), 32'h0);

        // Clear flags, then bypass: N=1 V=0 with B.LT in the same cycle.
        idle();
        alu_valid = 1; set_flags = 1; set_alu(4'b0000);
        step();
        chk("clr_nzcv", 32'(nzcv), 32'h0);
        chk("clr_res_valid", 32'(res_valid), 32'h0);
        set_alu(4'b1000);
        br_valid = 1; br_type = 2'd1; br_cond = 4'b1011;
        step();
        cnt++;
        chk("byp_taken", 32'(res_taken), 32'h1);
        chk("byp_nzcv", 32'(nzcv), 32'h8);

        // Full condition x flags sweep, flags written one cycle before the branch.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                idle();
                alu_valid = 1; set_flags = 1; set_alu(4'(f));
                step();
                idle();
                br_valid = 1; br_type = 2'd1; br_cond = 4'(c);
                step();
                exp_t = cond_ref(4'(c), 4'(f));
                if (exp_t) cnt++;
                chk($sformatf("sweep_c%0d_f%0d", c, f), 32'(res_taken), 32'(exp_t));
            end
        end
        chk("sweep_valid", 32'(res_valid), 32'h1);
        chk("sweep_count", taken_count, 32'(cnt));
        chk("sat_count", 32'(s_taken_count), sat3(cnt));

        // Backpressure: accept B, then stall three cycles with flags updating.
        idle();
        step();
        br_valid = 1; br_type = 2'd0; res_ready = 0;
        step();
        cnt++;
        chk("bp_acc_valid", 32'(res_valid), 32'h1);
        chk("bp_acc_taken", 32'(res_taken), 32'h1);
        br_type = 2'd3;
        alu_valid = 1; set_flags = 1; set_alu(4'b1101);
        for (int i = 0; i < 3; i++) begin
            chk("bp_br_ready", 32'(br_ready), 32'h0);
            step();
            chk("bp_hold_valid", 32'(res_valid), 32'h1);
            chk("bp_hold_taken", 32'(res_taken), 32'h1);
            chk("bp_nzcv", 32'(nzcv), 32'hd);
        end
        chk("bp_count_hold", taken_count, 32'(cnt));
        res_ready = 1;
        #1;
        chk("bp_release_ready", 32'(br_ready), 32'h1);
        step();
        chk("bp_next_valid", 32'(res_valid), 32'h1);
        chk("bp_next_taken", 32'(res_taken), 32'h0);

        // CBZ / CBNZ against live alu_zero, no flag write.
        idle();
        br_valid = 1; alu_valid = 1; alu_zero = 1; br_type = 2'd2;
        step();
        cnt++;
        chk("cbz_z1", 32'(res_taken), 32'h1);
        br_type = 2'd3;
        step();
        chk("cbnz_z1", 32'(res_taken), 32'h0);
        alu_zero = 0; br_type = 2'd2;
        step();
        chk("cbz_z0", 32'(res_taken), 32'h0);
        br_type = 2'd3;
        step();
        cnt++;
        chk("cbnz_z0", 32'(res_taken), 32'h1);
        alu_valid = 0; alu_zero = 1; br_type = 2'd2;
        step();
        chk("cbz_novalid", 32'(res_taken), 32'h0);
        br_type = 2'd3;
        step();
        chk("cbnz_novalid", 32'(res_taken), 32'h0);
        chk("cb_nzcv_hold", 32'(nzcv), 32'hd);
        chk("final_count", taken_count, 32'(cnt));
        chk("final_sat", 32'(s_taken_count), 32'h7);

        // Asynchronous reset mid-transfer drops the pending resolution at once.
        chk("pre_rst_valid", 32'(res_valid), 32'h1);
        #2;
        reset = 0;
        #1;
        chk("async_rst_valid", 32'(res_valid), 32'h0);
        chk("async_rst_count", taken_count, 32'h0);
        chk("async_rst_nzcv", 32'(nzcv), 32'h0);
        idle();
        step();
        reset = 1;
        step();
        chk("post_rst_valid", 32'(res_valid), 32'h0);
        chk("post_rst_ready", 32'(br_ready), 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
